// File: rtl/n_channel_2_input_gate.sv
// n_channel_2_input_gate
// CHANNELS independent 2-input gates sharing one function select (mode).
// Each gate result goes through a DELAY-cycle registered delay path.
// mode 3'b111 is HOLD: every piece of state is frozen and the inputs are ignored.
//
// Build option (macro INERTIAL_FILTER_EN):
//   undefined : transport delay. Each sample is shifted through DELAY register
//               stages, so pulses of any width are reproduced.
//   defined   : inertial delay. A per-channel saturating counter changes y[i]
//               only after r[i] has differed from y[i] for DELAY consecutive
//               non-HOLD samples. Shorter pulses are suppressed.
// valid rises after the DELAY-th non-HOLD edge that follows reset, and it
// behaves the same way in both builds.

module n_channel_2_input_gate #(
    parameter int CHANNELS = 4,
    parameter int DELAY    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] a,
    input  logic [CHANNELS-1:0] b,
    input  logic [2:0]          mode,
    output logic [CHANNELS-1:0] y,
    output logic                valid
);

    // Counter width: able to hold 0..DELAY
    localparam int                CW      = $clog2(DELAY + 1);
    localparam logic [CW-1:0]     DELAY_C = CW'(DELAY);
    localparam logic [CW-1:0]     ONE_C   = CW'(1);
    localparam logic [CW-1:0]     ZERO_C  = CW'(0);

    // Gate function applied bitwise to every channel. HOLD never reaches the pipeline.
    function automatic logic [CHANNELS-1:0] gate_fn(
        input logic [2:0]          m,
        input logic [CHANNELS-1:0] ga,
        input logic [CHANNELS-1:0] gb
    );
        logic [CHANNELS-1:0] res;
        case (m)
            3'b000:  res = ~(ga | gb);
            3'b001:  res = ~(ga & gb);
            3'b010:  res = ga | gb;
            3'b011:  res = ga & gb;
            3'b100:  res = ga ^ gb;
            3'b101:  res = ~(ga ^ gb);
            3'b110:  res = ~ga;
            default: res = {CHANNELS{1'b0}};
        endcase
        return res;
    endfunction

    logic                hold_s;
    logic                adv_s;
    logic [CHANNELS-1:0] r_s;

    assign hold_s = (mode == 3'b111);
    assign adv_s  = ~hold_s;
    assign r_s    = gate_fn(mode, a, b);

    // ------------------------------------------------------------------
    // valid: saturating count of non-HOLD edges since reset
    // ------------------------------------------------------------------
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic          valid_q, valid_d;

    // Next-state logic for the fill counter and valid
    always_comb begin
        vcnt_d  = vcnt_q;
        valid_d = valid_q;
        if (adv_s) begin
            if (vcnt_q == DELAY_C) begin
                vcnt_d = vcnt_q;
            end else begin
                vcnt_d = vcnt_q + ONE_C;
            end
            valid_d = (vcnt_d == DELAY_C);
        end else begin
            vcnt_d  = vcnt_q;
            valid_d = valid_q;
        end
    end

    // Fill counter and valid registers. Reset has priority over HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            vcnt_q  <= ZERO_C;
            valid_q <= 1'b0;
        end else begin
            vcnt_q  <= vcnt_d;
            valid_q <= valid_d;
        end
    end

    assign valid = valid_q;

`ifdef INERTIAL_FILTER_EN
    // ------------------------------------------------------------------
    // Inertial delay: per-channel mismatch run counter
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] y_q, y_d;
    logic [CW-1:0]       fcnt_q [CHANNELS];
    logic [CW-1:0]       fcnt_d [CHANNELS];

    // Per channel: count consecutive mismatches, and toggle y once DELAY is reached
    always_comb begin
        y_d = y_q;
        for (int i = 0; i < CHANNELS; i++) begin
            fcnt_d[i] = fcnt_q[i];
        end
        if (adv_s) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (r_s[i] != y_q[i]) begin
                    if (fcnt_q[i] == DELAY_C) begin
                        fcnt_d[i] = fcnt_q[i];
                    end else begin
                        fcnt_d[i] = fcnt_q[i] + ONE_C;
                    end
                    if (fcnt_d[i] >= DELAY_C) begin
                        y_d[i]    = ~y_q[i];
                        fcnt_d[i] = ZERO_C;
                    end else begin
                        y_d[i]    = y_q[i];
                    end
                end else begin
                    fcnt_d[i] = ZERO_C;
                    y_d[i]    = y_q[i];
                end
            end
        end else begin
            y_d = y_q;
        end
    end

    // Filter counters and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= {CHANNELS{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                fcnt_q[i] <= ZERO_C;
            end
        end else begin
            y_q <= y_d;
            for (int i = 0; i < CHANNELS; i++) begin
                fcnt_q[i] <= fcnt_d[i];
            end
        end
    end

    assign y = y_q;
`else
    // ------------------------------------------------------------------
    // Transport delay: DELAY-deep shift register. The last stage is y.
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] pipe_q [DELAY];
    logic [CHANNELS-1:0] pipe_d [DELAY];

    // Shift a new sample in on every non-HOLD edge
    always_comb begin
        for (int k = 0; k < DELAY; k++) begin
            pipe_d[k] = pipe_q[k];
        end
        if (adv_s) begin
            pipe_d[0] = r_s;
            for (int k = 1; k < DELAY; k++) begin
                pipe_d[k] = pipe_q[k-1];
            end
        end else begin
            for (int k = 0; k < DELAY; k++) begin
                pipe_d[k] = pipe_q[k];
            end
        end
    end

    // Delay stage registers. Reset discards any samples still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DELAY; k++) begin
                pipe_q[k] <= {CHANNELS{1'b0}};
            end
        end else begin
            for (int k = 0; k < DELAY; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
        end
    end

    assign y = pipe_q[DELAY-1];
`endif

endmodule
